md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Controls the E-stage multiply/divide resource: accepts one HI/LO operation per issue and times its multi-cycle latency with a down-counter.
- Holds the architectural HI/LO registers and commits results at the end of the latency window.
- Drives `busy` for the stall unit and serves mfhi/mflo reads combinationally.
- Gated by `req` so an instruction being flushed by an exception/interrupt never starts.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  E-stage instruction is a HI/LO-class op this cycle
- md_op  input  4  operation code, encodings in md_pkg
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- req  input  1  exception/interrupt flush; suppresses start this cycle
- busy  output  1  multi-cycle operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- md_rdata  output  32  mfhi→hi, mflo→lo, otherwise 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (`clk`, `reset`).
- Reset: state IDLE; busy=0; hi=0; lo=0; counter=0; shadow registers=0. Reset mid-operation aborts it, and nothing is committed.
- Effective issue: `go = start & !req`.
- md_op encodings:
  - 0000 none
  - 0001 mult
  - 0010 multu
  - 0011 div
  - 0100 divu
  - 0101 mthi
  - 0110 mfhi
  - 0111 mflo
  - 1000 mtlo
  - All other codes are treated as none.
- State machine: IDLE, BUSY.
  - IDLE, go with mult/multu/div/divu: compute the result from src_a/src_b into shadow hi_n/lo_n at this edge; load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - IDLE, go with mthi/mtlo: write src_a to hi/lo at this edge; stay IDLE; busy stays 0.
  - IDLE, go with mfhi/mflo/none: no state change.
  - BUSY, each edge: counter decrements. When counter==1, commit shadow to hi/lo and return to IDLE.
  - busy = (state==BUSY). The stall unit stalls on `start|busy`.
- Latency: for a start at cycle T with N cycles, busy is high in cycles T+1..T+N. The new hi/lo are visible in cycle T+N+1, the same cycle busy falls.
- start while BUSY: ignored (the stall unit prevents it). hi/lo and the counter are unaffected; this is checked by a bench assertion, not by RTL.
- req while BUSY: no effect. An already-issued operation always completes.
- Arithmetic rules:
  - mult: signed 32×32→64; hi = product[63:32], lo = product[31:0].
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero (src_b==0): full DIV_CYCLES busy window; hi/lo left unchanged at commit.
- md_rdata is purely combinational from the current hi/lo. mfhi issued in cycle T+N+1 reads the committed value.

Decomposition:
- md_pkg holds:
  - md_op encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO.
  - State encodings: S_IDLE, S_BUSY.
  - Default cycle counts.
- One combinational sub-module, md_arith (src_a, src_b, md_op → hi_n, lo_n, div_zero), isolates the signed/unsigned multiply/divide and the corner cases.
- md_sequencer owns the FSM, counter, shadow registers, HI/LO and the read mux.

Test Plan:
- mult 0xFFFFFFFE × 3, start pulse at T → busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, md_rdata(mflo)=0xFFFFFFFA.
- divu 7/2, then start+mfhi at T+3 → busy high 10 cycles; hi/lo stay old until T+11; then hi=1, lo=3; the start at T+3 is ignored.
- div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Separately, div 5/0 with hi=0x11, lo=0x22 → busy 10 cycles, hi/lo still 0x11/0x22.
- mthi 0xDEADBEEF with start=1, req=1 → hi unchanged, busy=0. Same stimulus with req=0 → hi=0xDEADBEEF next cycle, busy never asserts.
- mult 2×3 started, reset at T+2 → busy=0, hi=lo=0 at T+3, and no commit at T+6.
- Back-to-back: mtlo 0x5 at T, multu 0xFFFFFFFF×0xFFFFFFFF at T+1 → lo=5 at T+1; hi=0xFFFFFFFE, lo=0x00000001 at T+7.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide sequencer: HI/LO op codes,
// FSM states and default latencies.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'b0000,
        MD_MULT  = 4'b0001,
        MD_MULTU = 4'b0010,
        MD_DIV   = 4'b0011,
        MD_DIVU  = 4'b0100,
        MD_MTHI  = 4'b0101,
        MD_MFHI  = 4'b0110,
        MD_MFLO  = 4'b0111,
        MD_MTLO  = 4'b1000
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO arithmetic: signed/unsigned 32x32 multiply and divide,
// including the overflow and divide-by-zero corner cases.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  md_op,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        // Low 64 bits of an unsigned product of sign-extended operands equal the signed product.
        prod_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u   = {32'd0, src_a} * {32'd0, src_b};
        neg_a    = (md_op == MD_DIV) && src_a[31];
        neg_b    = (md_op == MD_DIV) && src_b[31];
        mag_a    = neg_a ? (32'd0 - src_a) : src_a;
        mag_b    = neg_b ? (32'd0 - src_b) : src_b;
        div_zero = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (src_b == '0);
        divisor  = (mag_b == '0) ? 32'd1 : mag_b;
        // Magnitude division makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
        quot     = mag_a / divisor;
        rem      = mag_a % divisor;
        hi_n     = '0;
        lo_n     = '0;
        case (md_op)
            MD_MULT: begin
                hi_n = prod_s[63:32];
                lo_n = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_n = prod_u[63:32];
                lo_n = prod_u[31:0];
            end
            MD_DIV: begin
                lo_n = (neg_a ^ neg_b) ? (32'd0 - quot) : quot;
                hi_n = neg_a ? (32'd0 - rem) : rem;
            end
            MD_DIVU: begin
                lo_n = quot;
                hi_n = rem;
            end
            default: begin
                hi_n = '0;
                lo_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: issues one HI/LO op, times its latency
// with a down-counter, commits shadow results into HI/LO and serves mfhi/mflo.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    state_e      state;
    state_e      state_nxt;
    logic [3:0]  count;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    logic        skip_commit;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        div_zero;
    logic        go;
    logic        issue_md;
    logic        last;
    logic [3:0]  load_cycles;

    md_arith u_arith (
        .src_a    (src_a),
        .src_b    (src_b),
        .md_op    (md_op),
        .hi_n     (hi_n),
        .lo_n     (lo_n),
        .div_zero (div_zero)
    );

    assign go          = start & ~req;
    assign issue_md    = go && is_md_arith(md_op);
    assign last        = (count == 4'd1);
    assign load_cycles = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? 4'(MULT_CYCLES)
                                                                      : 4'(DIV_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue_md) state_nxt = S_BUSY;
            S_BUSY:  if (last)     state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_BUSY);
        md_rdata = '0;
        case (md_op)
            MD_MFHI: md_rdata = hi;
            MD_MFLO: md_rdata = lo;
            default: md_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            hi_s        <= '0;
            lo_s        <= '0;
            skip_commit <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else if (state == S_IDLE) begin
            if (issue_md) begin
                count       <= load_cycles;
                hi_s        <= hi_n;
                lo_s        <= lo_n;
                skip_commit <= div_zero;
            end else if (go && (md_op == MD_MTHI)) begin
                hi <= src_a;
            end else if (go && (md_op == MD_MTLO)) begin
                lo <= src_a;
            end
        end else begin
            count <= count - 4'd1;
            // Divide by zero still burns the full window but leaves HI/LO untouched.
            if (last && !skip_commit) begin
                hi <= hi_s;
                lo <= lo_s;
            end
        end
    end

endmodule
